// File: rtl/uart_cmd_rx_if.sv
// Signal bundle between the UART command receiver and its host:
// the RX line in, the received byte and decoded command outputs.
interface uart_cmd_rx_if;
    logic       RX;
    logic [7:0] rx_byte;
    logic       rx_byte_valid;
    logic [7:0] key_value;
    logic [7:0] key_arg;
    logic       cmd_valid;
    logic       frame_err;
    logic       sum_err;

    modport slave (
        input  RX,
        output rx_byte, rx_byte_valid, key_value, key_arg,
        output cmd_valid, frame_err, sum_err
    );

    modport master (
        output RX,
        input  rx_byte, rx_byte_valid, key_value, key_arg,
        input  cmd_valid, frame_err, sum_err
    );
endinterface

// File: rtl/uart_cmd_rx.sv
// 8N1 UART receiver feeding a header/cmd/arg/checksum frame parser that
// drives the held key_value/key_arg command bus.
module uart_cmd_rx #(
    parameter int         CLK_FREQ     = 50_000_000,
    parameter int         BAUD         = 115200,
    parameter logic [7:0] HEADER       = 8'hA5,
    parameter int         TIMEOUT_BITS = 40
) (
    input  logic          clk,
    input  logic          rst_n,
    uart_cmd_rx_if.slave  bus
);

    localparam int BIT_CYC  = CLK_FREQ / BAUD;
    localparam int HALF_CYC = BIT_CYC / 2;
    localparam int TO_CYC   = TIMEOUT_BITS * BIT_CYC;
    localparam int BAUD_W   = $clog2(BIT_CYC + 1);
    localparam int TO_W     = $clog2(TO_CYC + 1);

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BIT_CYC - 1);
    localparam logic [BAUD_W-1:0] HALF_LAST = BAUD_W'(HALF_CYC - 1);
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TO_CYC - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [1:0] {P_WAIT_HDR, P_GET_CMD, P_GET_ARG, P_GET_SUM} p_state_t;

    // ---------------- RX synchroniser and edge detect ----------------
    logic r_rx_meta;
    logic r_rx_sync;
    logic r_rx_prev;
    logic w_rx_fall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_meta <= bus.RX;
            r_rx_sync <= r_rx_meta;
            r_rx_prev <= r_rx_sync;
        end
    end

    // Edge rather than level, so a stop bit held low cannot retrigger a start.
    assign w_rx_fall = r_rx_prev & ~r_rx_sync;

    // ---------------- Bit receiver ----------------
    rx_state_t         r_rx_state;
    rx_state_t         w_rx_state_nxt;
    logic [BAUD_W-1:0] r_baud_cnt;
    logic [2:0]        r_bit_idx;
    logic [7:0]        r_shift;
    logic [7:0]        r_rx_byte;
    logic              r_rx_byte_valid;
    logic              r_frame_err;
    logic              w_baud_tick;
    logic              w_byte_done;
    logic              w_stop_bad;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_rx_state <= RX_IDLE;
        else        r_rx_state <= w_rx_state_nxt;
    end

    always_comb begin
        w_rx_state_nxt = r_rx_state;
        w_baud_tick    = 1'b0;
        w_byte_done    = 1'b0;
        w_stop_bad     = 1'b0;
        case (r_rx_state)
            RX_IDLE: begin
                if (w_rx_fall) w_rx_state_nxt = RX_START;
            end
            RX_START: begin
                w_baud_tick = (r_baud_cnt == HALF_LAST);
                if (w_baud_tick) w_rx_state_nxt = r_rx_sync ? RX_IDLE : RX_DATA;
            end
            RX_DATA: begin
                w_baud_tick = (r_baud_cnt == BAUD_LAST);
                if (w_baud_tick && (r_bit_idx == 3'd7)) w_rx_state_nxt = RX_STOP;
            end
            RX_STOP: begin
                w_baud_tick = (r_baud_cnt == BAUD_LAST);
                if (w_baud_tick) begin
                    w_rx_state_nxt = RX_IDLE;
                    w_byte_done    = r_rx_sync;
                    w_stop_bad     = ~r_rx_sync;
                end
            end
            default: w_rx_state_nxt = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_baud_cnt      <= '0;
            r_bit_idx       <= 3'd0;
            r_shift         <= 8'h00;
            r_rx_byte       <= 8'h00;
            r_rx_byte_valid <= 1'b0;
            r_frame_err     <= 1'b0;
        end else begin
            if ((r_rx_state == RX_IDLE) || w_baud_tick) r_baud_cnt <= '0;
            else                                        r_baud_cnt <= r_baud_cnt + 1'b1;

            if (r_rx_state == RX_START && w_baud_tick) r_bit_idx <= 3'd0;
            else if (r_rx_state == RX_DATA && w_baud_tick) begin
                r_bit_idx <= r_bit_idx + 3'd1;
                r_shift   <= {r_rx_sync, r_shift[7:1]};
            end

            if (w_byte_done) r_rx_byte <= r_shift;
            r_rx_byte_valid <= w_byte_done;
            r_frame_err     <= w_stop_bad;
        end
    end

    // ---------------- Frame parser ----------------
    p_state_t        r_p_state;
    p_state_t        w_p_state_nxt;
    logic [7:0]      r_cmd;
    logic [7:0]      r_arg;
    logic [7:0]      w_sum;
    logic [7:0]      r_key_value;
    logic [7:0]      r_key_arg;
    logic            r_cmd_valid;
    logic            r_sum_err;
    logic [TO_W-1:0] r_to_cnt;
    logic            w_timeout;
    logic            w_cmd_ok;
    logic            w_sum_bad;

    assign w_sum     = r_cmd + r_arg;
    assign w_timeout = (r_p_state != P_WAIT_HDR) && (r_to_cnt == TO_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_p_state <= P_WAIT_HDR;
        else        r_p_state <= w_p_state_nxt;
    end

    // A received byte wins over a timeout expiring on the same clock.
    always_comb begin
        w_p_state_nxt = r_p_state;
        w_cmd_ok      = 1'b0;
        w_sum_bad     = 1'b0;
        if (r_frame_err) begin
            w_p_state_nxt = P_WAIT_HDR;
        end else if (r_rx_byte_valid) begin
            case (r_p_state)
                P_WAIT_HDR: if (r_rx_byte == HEADER) w_p_state_nxt = P_GET_CMD;
                P_GET_CMD:  w_p_state_nxt = P_GET_ARG;
                P_GET_ARG:  w_p_state_nxt = P_GET_SUM;
                P_GET_SUM: begin
                    w_p_state_nxt = P_WAIT_HDR;
                    w_cmd_ok      = (r_rx_byte == w_sum);
                    w_sum_bad     = (r_rx_byte != w_sum);
                end
                default: w_p_state_nxt = P_WAIT_HDR;
            endcase
        end else if (w_timeout) begin
            w_p_state_nxt = P_WAIT_HDR;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cmd       <= 8'h00;
            r_arg       <= 8'h00;
            r_key_value <= 8'h00;
            r_key_arg   <= 8'h00;
            r_cmd_valid <= 1'b0;
            r_sum_err   <= 1'b0;
            r_to_cnt    <= '0;
        end else begin
            if (r_rx_byte_valid && r_p_state == P_GET_CMD) r_cmd <= r_rx_byte;
            if (r_rx_byte_valid && r_p_state == P_GET_ARG) r_arg <= r_rx_byte;
            if (w_cmd_ok) begin
                r_key_value <= r_cmd;
                r_key_arg   <= r_arg;
            end
            r_cmd_valid <= w_cmd_ok;
            r_sum_err   <= w_sum_bad;

            if ((r_p_state == P_WAIT_HDR) || r_rx_byte_valid) r_to_cnt <= '0;
            else if (r_to_cnt != TO_LAST)                     r_to_cnt <= r_to_cnt + 1'b1;
        end
    end

    assign bus.rx_byte       = r_rx_byte;
    assign bus.rx_byte_valid = r_rx_byte_valid;
    assign bus.frame_err     = r_frame_err;
    assign bus.key_value     = r_key_value;
    assign bus.key_arg       = r_key_arg;
    assign bus.cmd_valid     = r_cmd_valid;
    assign bus.sum_err       = r_sum_err;

endmodule

// File: tb/tb_uart_cmd_rx.sv
// Scoreboard bench for uart_cmd_rx: a frame-level reference model queues
// expected byte/command events, an independent monitor checks DUT pulses.
module tb_uart_cmd_rx;

    localparam int         CLK_FREQ     = 1_600_000;
    localparam int         BAUD         = 100_000;
    localparam int         BIT_CYC      = CLK_FREQ / BAUD;
    localparam int         TIMEOUT_BITS = 40;
    localparam logic [7:0] HDR          = 8'hA5;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    uart_cmd_rx_if bus ();

    uart_cmd_rx #(
        .CLK_FREQ    (CLK_FREQ),
        .BAUD        (BAUD),
        .HEADER      (HDR),
        .TIMEOUT_BITS(TIMEOUT_BITS)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    typedef struct packed {
        bit         is_err;
        logic [7:0] v;
        logic [7:0] a;
    } ev_t;

    ev_t        q_byte[$];
    ev_t        q_cmd[$];
    logic [7:0] pend[$];
    logic [7:0] m_key  = 8'h00;
    logic [7:0] m_arg  = 8'h00;
    logic [7:0] m_last = 8'h00;

    int checks = 0;
    int errors = 0;

    task automatic report(string name, logic [7:0] act, logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %02h, expected %02h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    task automatic m_feed(logic [7:0] b);
        logic [7:0] s;
        q_byte.push_back('{is_err: 1'b0, v: b, a: 8'h00});
        m_last = b;
        if (pend.size() == 0) begin
            if (b == HDR) pend.push_back(b);
        end else begin
            pend.push_back(b);
            if (pend.size() == 4) begin
                s = pend[1] + pend[2];
                if (s == pend[3]) begin
                    m_key = pend[1];
                    m_arg = pend[2];
                    q_cmd.push_back('{is_err: 1'b0, v: m_key, a: m_arg});
                end else begin
                    q_cmd.push_back('{is_err: 1'b1, v: m_key, a: m_arg});
                end
                pend.delete();
            end
        end
    endtask

    task automatic m_ferr();
        q_byte.push_back('{is_err: 1'b1, v: m_last, a: 8'h00});
        pend.delete();
    endtask

    task automatic m_reset();
        pend.delete();
        q_byte.delete();
        q_cmd.delete();
        m_key  = 8'h00;
        m_arg  = 8'h00;
        m_last = 8'h00;
    endtask

    // ---------------- monitor ----------------
    ev_t mb, mc;
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.rx_byte_valid || bus.frame_err) begin
                if (bus.rx_byte_valid && bus.frame_err) begin
                    report("byte_pulse_overlap", 8'h01, 8'h00);
                end else if (q_byte.size() == 0) begin
                    report("unexpected_byte_pulse", {7'd0, bus.frame_err}, 8'hFF);
                end else begin
                    mb = q_byte.pop_front();
                    report("byte_kind_ferr", {7'd0, bus.frame_err}, {7'd0, mb.is_err});
                    report("rx_byte", bus.rx_byte, mb.v);
                end
            end
            if (bus.cmd_valid || bus.sum_err) begin
                if (bus.cmd_valid && bus.sum_err) begin
                    report("cmd_pulse_overlap", 8'h01, 8'h00);
                end else if (q_cmd.size() == 0) begin
                    report("unexpected_cmd_pulse", {7'd0, bus.sum_err}, 8'hFF);
                end else begin
                    mc = q_cmd.pop_front();
                    report("cmd_kind_sumerr", {7'd0, bus.sum_err}, {7'd0, mc.is_err});
                    report("key_value", bus.key_value, mc.v);
                    report("key_arg", bus.key_arg, mc.a);
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic wait_clk(int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic tx_raw(logic [7:0] b, bit stop_ok);
        bus.RX = 1'b0;
        wait_clk(BIT_CYC);
        for (int i = 0; i < 8; i++) begin
            bus.RX = b[i];
            wait_clk(BIT_CYC);
        end
        bus.RX = stop_ok;
        wait_clk(BIT_CYC);
        bus.RX = 1'b1;
    endtask

    task automatic idle_bits(int n);
        bus.RX = 1'b1;
        wait_clk(n * BIT_CYC);
    endtask

    task automatic send(logic [7:0] b);
        m_feed(b);
        tx_raw(b, 1'b1);
    endtask

    task automatic send4(logic [7:0] b0, logic [7:0] b1, logic [7:0] b2, logic [7:0] b3);
        send(b0); send(b1); send(b2); send(b3);
    endtask

    task automatic check_reset_outputs(string tag);
        report({tag, "_rx_byte"},   bus.rx_byte, 8'h00);
        report({tag, "_key_value"}, bus.key_value, 8'h00);
        report({tag, "_key_arg"},   bus.key_arg, 8'h00);
        report({tag, "_pulses"},
               {4'd0, bus.rx_byte_valid, bus.frame_err, bus.cmd_valid, bus.sum_err}, 8'h00);
    endtask

    logic [7:0] rc, ra, rs, rj;

    initial begin
        bus.RX = 1'b1;
        rst_n  = 1'b0;
        wait_clk(5);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;
        idle_bits(2);

        // valid frame
        send4(8'hA5, 8'h01, 8'h10, 8'h11);
        idle_bits(2);
        report("valid_key", bus.key_value, 8'h01);
        report("valid_arg", bus.key_arg, 8'h10);

        // checksum error leaves held outputs alone
        send4(8'hA5, 8'h02, 8'h10, 8'hFF);
        idle_bits(2);
        report("sumerr_key_held", bus.key_value, 8'h01);

        // short glitch, then a byte with a low stop bit
        bus.RX = 1'b0;
        wait_clk(3);
        bus.RX = 1'b1;
        idle_bits(2);
        m_ferr();
        tx_raw(8'h55, 1'b0);
        idle_bits(2);
        report("ferr_rx_byte_kept", bus.rx_byte, 8'hFF);

        // inter-byte timeout then a clean frame
        send(8'hA5);
        send(8'h07);
        pend.delete();
        idle_bits(50);
        send4(8'hA5, 8'h03, 8'h04, 8'h07);
        idle_bits(1);
        report("timeout_key", bus.key_value, 8'h03);
        report("timeout_arg", bus.key_arg, 8'h04);

        // back-to-back, header value used as command
        send4(8'hA5, 8'hA5, 8'h00, 8'hA5);
        report("embedded_hdr_key", bus.key_value, 8'hA5);
        send4(8'hA5, 8'h02, 8'h02, 8'h04);
        idle_bits(1);
        report("b2b_key", bus.key_value, 8'h02);

        // reset in the middle of the argument byte
        send(8'hA5);
        send(8'h09);
        fork
            tx_raw(8'h33, 1'b1);
            begin
                wait_clk(BIT_CYC * 4);
                #1;
                rst_n = 1'b0;
                m_reset();
                #1;
                check_reset_outputs("midreset");
            end
        join
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle_bits(2);
        send4(8'hA5, 8'h09, 8'h01, 8'h0A);
        idle_bits(1);
        report("postreset_key", bus.key_value, 8'h09);
        report("postreset_arg", bus.key_arg, 8'h01);

        // randomized traffic: junk bytes, bad sums, framing errors, small gaps
        for (int k = 0; k < 40; k++) begin
            for (int j = 0; j < int'($urandom_range(0, 2)); j++) begin
                rj = 8'($urandom);
                if (rj == HDR) rj = 8'h5A;
                send(rj);
                idle_bits($urandom_range(0, 2));
            end
            rc = 8'($urandom);
            ra = 8'($urandom);
            rs = rc + ra;
            if ($urandom_range(0, 3) == 0) rs = rs + 8'($urandom_range(1, 255));
            send(HDR);
            idle_bits($urandom_range(0, 1));
            send(rc);
            if ($urandom_range(0, 9) == 0) begin
                m_ferr();
                tx_raw(8'($urandom), 1'b0);
                idle_bits(1);
            end
            send(ra);
            idle_bits($urandom_range(0, 1));
            send(rs);
            idle_bits($urandom_range(0, 2));
        end

        idle_bits(3);
        report("byte_events_left", 8'(q_byte.size()), 8'h00);
        report("cmd_events_left", 8'(q_cmd.size()), 8'h00);
        report("final_key", bus.key_value, m_key);
        report("final_arg", bus.key_arg, m_arg);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_cmd_rx.md
# uart_cmd_rx

Receive-side command decoder for the ESP8266 serial link. It turns the 8N1 byte stream on the RX pin into validated command frames. It then drives the held `key_value` bus that the motor, beep, engine and automation blocks decode. It complements the telemetry transmit path, which produces sensor ASCII frames: this block consumes framed commands from the same UART link, replaces the raw last-byte-received path, and adds a header, an argument byte and a checksum.

## Interface
Parameters:
- `CLK_FREQ`, 50_000_000, system clock in Hz
- `BAUD`, 115200, line rate; `BIT_CYC = CLK_FREQ/BAUD` (integer truncation, 434 at defaults)
- `HEADER`, 8'hA5, frame start byte
- `TIMEOUT_BITS`, 40, idle bit periods allowed between bytes inside a frame

Ports:
- `clk` in 1: system clock, 50 MHz
- `rst_n` in 1: reset, asynchronous assert, active-low
- `RX` in 1: asynchronous UART line, idle high
- `rx_byte` out 8: last correctly framed byte
- `rx_byte_valid` out 1: one-cycle pulse, `rx_byte` updated
- `key_value` out 8: command byte of last valid frame, held
- `key_arg` out 8: argument byte of last valid frame, held
- `cmd_valid` out 1: one-cycle pulse, new command latched
- `frame_err` out 1: one-cycle pulse, stop bit sampled low
- `sum_err` out 1: one-cycle pulse, checksum mismatch

## Operation
- **RX synchroniser:** `RX` passes through a 2-flop synchroniser, reset value 1. All logic uses only the synchronised signal.
- **Bit receiver FSM** (IDLE, START, DATA, STOP):
  - IDLE: a synchronised falling level starts the baud counter and enters START.
  - START: samples at `BIT_CYC/2`. If the line is high, it is a false start and the FSM returns to IDLE with no pulse. If low, the FSM enters DATA.
  - DATA: samples 8 bits LSB first, each `BIT_CYC` after the previous sample.
  - STOP: samples once, `BIT_CYC` later. High means `rx_byte` is loaded and `rx_byte_valid` pulses. Low means `frame_err` pulses and the byte is discarded. The FSM then returns to IDLE.
  - IDLE is re-entered at the stop-bit midpoint, so a start bit arriving immediately after is detected.
- **Frame parser FSM** (WAIT_HDR, GET_CMD, GET_ARG, GET_SUM). It advances only on `rx_byte_valid`.
  - WAIT_HDR: a byte equal to `HEADER` moves to GET_CMD. Any other byte is ignored.
  - GET_CMD: stores `cmd`, moves to GET_ARG.
  - GET_ARG: stores `arg`, moves to GET_SUM.
  - GET_SUM: the byte is compared with `(cmd + arg) mod 256`. On a match, `key_value<=cmd`, `key_arg<=arg` and `cmd_valid` pulses. On a mismatch, `sum_err` pulses and the held outputs are unchanged. Both cases return to WAIT_HDR.
  - A byte equal to `HEADER` inside a frame is treated as data; there is no resynchronisation on it.
  - `frame_err` in any parser state forces WAIT_HDR.
- **Inter-byte timeout:**
  - Counts clocks while the parser is not in WAIT_HDR. The counter clears on each `rx_byte_valid`.
  - Reaching `TIMEOUT_BITS*BIT_CYC` clocks forces WAIT_HDR silently, with no error pulse.
  - The counter must be wide enough for 17360 at defaults (15 bits minimum; size it from the parameters).
- **Reset values:** `rx_byte`=0, `key_value`=0x00, `key_arg`=0x00. All pulses are 0. Both FSMs go to their idle states.
- **Reset mid-byte or mid-frame:** any partial byte or frame is abandoned, with no pulse on release.

## Timing
- `rx_byte_valid` and `frame_err` are registered: high on the clock after the stop-bit sample clock, for exactly 1 cycle.
- Sample clock offset from the `RX` pin's falling edge is 2 (sync) + `BIT_CYC/2` + 9·`BIT_CYC` clocks, ±1.
- `cmd_valid` and `sum_err` assert on the clock after the `rx_byte_valid` of the checksum byte. `key_value`/`key_arg` change on that same edge.
- Pulses never overlap:
  - at most one of `rx_byte_valid`/`frame_err` per byte;
  - at most one of `cmd_valid`/`sum_err` per frame.
- Back-to-back frames with zero idle gap must be accepted. The parser is ready for the next header in the cycle `cmd_valid` asserts.
- Throughput is 1 byte per 10 `BIT_CYC`; no buffering is needed.

## Test plan
- **Valid frame:** A5 01 10 11 at 115200 -> four `rx_byte_valid` pulses; one `cmd_valid`; `key_value`=0x01, `key_arg`=0x10, held until the next valid frame.
- **Checksum error:**
  - first, a valid frame A5 01 10 11 -> `key_value`=0x01;
  - then A5 02 10 FF -> one `sum_err` pulse, no `cmd_valid`, `key_value` still 0x01.
- **Glitch and framing error:**
  - `RX` low for 100 clocks -> no pulses;
  - then byte 0x55 with its stop bit held low -> one `frame_err`, `rx_byte` unchanged.
- **Timeout resync:**
  - A5 07, then idle for 50 bit periods, then A5 03 04 07 -> `cmd_valid` once, `key_value`=0x03, `key_arg`=0x04;
  - no error pulses.
- **Back-to-back and embedded header:** A5 A5 00 A5 immediately followed by A5 02 02 04 -> `key_value`=0xA5 then 0x02, two `cmd_valid` pulses.
- **Reset mid-frame:**
  - assert `rst_n` low during the argument byte of A5 09 ..;
  - all outputs go to reset values immediately;
  - the following full frame A5 09 01 0A decodes to `key_value`=0x09.
